demux4_buf: RTL and testbench
=============================

DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the per-channel transfer counter width.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_data, input, WIDTH: word to route.
REQ-006 Port in_sel, input, 2: destination channel (0=a, 1=b, 2=c, 3=d).
REQ-007 Port in_valid, input, 1: source offers in_data/in_sel.
REQ-008 Port in_ready, output, 1: block accepts the offered word this cycle.
REQ-009 Ports out_a, out_b, out_c, out_d, output, WIDTH each: buffered word per channel.
REQ-010 Port out_valid, output, 4: bit k means channel k holds a word.
REQ-011 Port out_ready, input, 4: bit k means the sink of channel k takes the word this cycle.
REQ-012 Ports cnt_a, cnt_b, cnt_c, cnt_d, output, CNT_W each: words accepted per channel.

Function
REQ-013 A transfer SHALL occur in a cycle exactly when in_valid and in_ready are both 1.
REQ-014 Each channel SHALL hold a one-entry buffer with two states: EMPTY and FULL.
REQ-015 Channel states SHALL transition as follows: EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on accept plus drain.
REQ-016 in_ready SHALL be combinational: 1 when rst=0 and channel in_sel is EMPTY or out_ready[in_sel]=1; otherwise 0.
REQ-017 An accepted word SHALL appear on its channel output with out_valid[k]=1 in the cycle after acceptance (latency 1).
REQ-018 out_valid[k] SHALL equal 1 exactly when channel k is FULL.
REQ-019 A drain on channel k SHALL occur when out_valid[k] and out_ready[k] are both 1.
REQ-020 While out_valid[k]=1 and out_ready[k]=0, out_k SHALL hold stable.
REQ-021 When accept and drain hit the same channel in one cycle, the drained word SHALL be the old one, the new word SHALL be loaded, and the channel SHALL stay FULL.
REQ-022 Channels not addressed by in_sel SHALL be unaffected by the input side; drains on different channels in the same cycle SHALL proceed independently.
REQ-023 When in_valid=0, in_sel and in_data SHALL be ignored.
REQ-024 A source holding in_valid=1 without acceptance SHALL keep in_data and in_sel stable; the block relies on this rule.
REQ-025 cnt_k SHALL increment by 1 on each accept to channel k, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 out_k SHALL read as 0 until channel k receives its first word after reset.

Reset
REQ-027 With rst=1 at a clock edge, all channels SHALL go EMPTY, out_valid SHALL be 0, out_a..out_d SHALL be 0, and cnt_a..cnt_d SHALL be 0.
REQ-028 A reset asserted while words are buffered SHALL discard them without drain.
REQ-029 An input offered in the reset cycle SHALL NOT be accepted and SHALL NOT be counted.
REQ-030 The first accept SHALL be possible in the first cycle with rst=0.

Structure
REQ-031 A shared package SHALL hold NUM_CH=4, SEL_W=2, and the channel-state enum {EMPTY, FULL}.
REQ-032 One sub-module, demux4_slot, SHALL implement a single channel: buffer, state and counter.
REQ-033 demux4_buf SHALL instantiate demux4_slot four times.
REQ-034 demux4_buf SHALL contain only select decode, in_ready generation, and port wiring.

Verification
REQ-035 Basic routing: after reset, send 0x00000001..0x00000004 with sel 0..3 while out_ready=4'b1111. Each word SHALL appear on out_a..out_d one cycle after its accept, and each cnt SHALL equal 1.
REQ-036 Backpressure: with out_ready[1]=0, send 0xAAAA0000 then 0xBBBB0000 to sel=1. The second offer SHALL see in_ready=0, and out_b SHALL hold 0xAAAA0000. Raising out_ready[1] SHALL give in_ready=1 in the same cycle, and 0xBBBB0000 SHALL appear in the next cycle.
REQ-037 Independence: with channel c FULL and stalled, a word 0x12345678 sent to sel=3 SHALL be accepted immediately, and out_c SHALL be unchanged.
REQ-038 Counter wrap: 256 accepts to sel=0 SHALL leave cnt_a=0, with cnt_b..cnt_d=0.
REQ-039 Reset mid-operation: with all channels FULL, assert rst for 1 cycle while in_valid=1. Afterwards out_valid SHALL be 0, all outputs 0, all counts 0, and nothing SHALL have been accepted.
REQ-040 Same-cycle accept and drain: with channel d FULL holding 0x11 and out_ready[3]=1, send 0x22 to sel=3. The sink SHALL see 0x11 that cycle and 0x22 the next, with out_valid[3] staying 1.

Source files
------------

// File: rtl/demux4_buf_pkg.sv
// demux4_buf_pkg: channel count, select width and the one-entry buffer state shared by demux4_buf and demux4_slot
package demux4_buf_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;
endpackage

// File: rtl/demux4_slot.sv
// demux4_slot: one output channel (one-entry buffer, EMPTY/FULL state, accept counter); ports clk, rst, accept, in_data, out_ready -> out_data, out_valid, cnt
module demux4_slot
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt
);
  ch_state_t        r_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;
  assign w_drain = (r_state == FULL) && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (accept) begin
        r_data <= in_data;
        r_cnt  <= r_cnt + 1'b1;
      end
      r_state <= accept ? FULL : (w_drain ? EMPTY : r_state);
    end
  end
  assign out_data  = r_data;
  assign out_valid = (r_state == FULL);
  assign cnt       = r_cnt;
endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: routes one valid/ready input stream to four buffered channels a..d by in_sel, with per-channel accept counters; ports in_data/in_sel/in_valid/in_ready, out_a..d/out_valid/out_ready, cnt_a..d
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic [WIDTH-1:0]  out_c,
  output logic [WIDTH-1:0]  out_d,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  output logic [CNT_W-1:0]  cnt_d
);
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_accept;
  logic [WIDTH-1:0]  w_data [NUM_CH];
  logic [CNT_W-1:0]  w_cnt  [NUM_CH];
  // a FULL slot can still take a word when its sink drains in the same cycle
  assign in_ready = !rst && (!w_valid[in_sel] || out_ready[in_sel]);
  assign w_accept = (in_valid && in_ready) ? (NUM_CH'(1) << in_sel) : '0;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux4_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .accept    (w_accept[k]),
      .in_data   (in_data),
      .out_ready (out_ready[k]),
      .out_data  (w_data[k]),
      .out_valid (w_valid[k]),
      .cnt       (w_cnt[k])
    );
  end
  assign out_valid = w_valid;
  assign out_a     = w_data[0];
  assign out_b     = w_data[1];
  assign out_c     = w_data[2];
  assign out_d     = w_data[3];
  assign cnt_a     = w_cnt[0];
  assign cnt_b     = w_cnt[1];
  assign cnt_c     = w_cnt[2];
  assign cnt_d     = w_cnt[3];
endmodule

// File: tb/tb_demux4_buf.sv
// tb_demux4_buf: scoreboard bench for demux4_buf with directed vectors and a negedge monitor
module tb_demux4_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_a, out_b, out_c, out_d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;
  logic [31:0] outs [4];
  logic [31:0] exp_q [4][$];
  string       chk_n [$];
  logic [63:0] chk_a [$];
  logic [63:0] chk_e [$];
  int          n_cmp = 0;
  int          n_err = 0;

  demux4_buf #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_d     (cnt_d)
  );

  always #5 clk = ~clk;
  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;
  assign outs[3] = out_d;

  always @(negedge clk) begin
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      if (!rst && out_valid[k] && out_ready[k]) begin
        n_cmp++;
        if (exp_q[k].size() == 0) begin
          n_err++;
          $display("FAIL drain_ch%0d: got %h, expected no word pending", k, outs[k]);
        end else begin
          e = exp_q[k].pop_front();
          if (outs[k] !== e) begin
            n_err++;
            $display("FAIL drain_ch%0d: got %h, expected %h", k, outs[k], e);
          end
        end
      end
    end
    while (chk_n.size() > 0) begin
      string       n;
      logic [63:0] a, x;
      n = chk_n.pop_front();
      a = chk_a.pop_front();
      x = chk_e.pop_front();
      n_cmp++;
      if (a !== x) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", n, a, x);
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    chk_n.push_back(n);
    chk_a.push_back(a);
    chk_e.push_back(e);
  endtask

  task automatic offer(input logic [1:0] s, input logic [31:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sel = s;
    in_data = d;
  endtask

  task automatic take(input int max);
    bit ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk($sformatf("accept_sel%0d", in_sel), 64'(ok), 64'd1);
    if (ok) exp_q[in_sel].push_back(in_data);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] d);
    offer(s, d);
    take(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wrap_ok;
    out_ready = 4'hF;
    @(negedge clk);
    chk("ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    chk("rst_out_d", 64'(out_d), 64'd0);
    chk("rst_cnt_a", 64'(cnt_a), 64'd0);
    chk("first_cycle_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 32'(i + 1));
      @(negedge clk);
      chk($sformatf("latency_ch%0d", i), 64'(out_valid[i]), 64'd1);
    end
    chk("basic_cnt_a", 64'(cnt_a), 64'd1);
    chk("basic_cnt_b", 64'(cnt_b), 64'd1);
    chk("basic_cnt_c", 64'(cnt_c), 64'd1);
    chk("basic_cnt_d", 64'(cnt_d), 64'd1);

    @(posedge clk);
    #1;
    out_ready = 4'b1101;
    send(2'd1, 32'hAAAA0000);
    offer(2'd1, 32'hBBBB0000);
    @(negedge clk);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_b", 64'(out_b), 64'hAAAA0000);
    @(negedge clk);
    chk("bp_out_b_hold", 64'(out_b), 64'hAAAA0000);
    chk("bp_valid_hold", 64'(out_valid[1]), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    take(1);
    @(negedge clk);
    chk("bp_out_b_new", 64'(out_b), 64'hBBBB0000);

    @(posedge clk);
    #1;
    out_ready = 4'b1011;
    send(2'd2, 32'hCCCC0000);
    offer(2'd3, 32'h12345678);
    take(1);
    @(negedge clk);
    chk("ind_out_c", 64'(out_c), 64'hCCCC0000);
    chk("ind_valid_c", 64'(out_valid[2]), 64'd1);
    chk("ind_out_d", 64'(out_d), 64'h12345678);
    @(posedge clk);
    #1;
    out_ready = 4'b0111;
    send(2'd3, 32'h11);
    @(posedge clk);
    #1;
    out_ready = 4'hF;
    in_valid = 1'b1;
    in_sel = 2'd3;
    in_data = 32'h22;
    take(1);
    @(negedge clk);
    chk("same_valid_d", 64'(out_valid[3]), 64'd1);
    chk("same_out_d", 64'(out_d), 64'h22);

    @(posedge clk);
    #1;
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) send(2'(i), 32'hF0 + 32'(i));
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_sel = 2'd2;
    in_data = 32'hDEAD;
    @(negedge clk);
    chk("rstmid_full", 64'(out_valid), 64'hF);
    chk("rstmid_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_outs", {out_a, out_b} | {out_c, out_d}, 64'd0);
    chk("rstmid_cnt_a", 64'(cnt_a), 64'd0);
    chk("rstmid_cnt_c", 64'(cnt_c), 64'd0);
    chk("rstmid_cnts", 64'({cnt_b, cnt_d}), 64'd0);

    @(posedge clk);
    #1;
    out_ready = 4'hF;
    wrap_ok = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_sel = 2'd0;
      in_data = 32'h100 + 32'(i);
      @(negedge clk);
      if (i == 255) chk("wrap_cnt_255", 64'(cnt_a), 64'd255);
      if (in_ready) begin
        exp_q[0].push_back(in_data);
        wrap_ok++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_accepts", 64'(wrap_ok), 64'd256);
    chk("wrap_cnt_a", 64'(cnt_a), 64'd0);
    chk("wrap_cnt_bcd", 64'({cnt_b, cnt_c, cnt_d}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk($sformatf("left_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
